// File: rtl/mold_pkg.sv
// Shared types and lane widths for the MoldUDP64 -> ITCH message buffer.
package mold_pkg;
    localparam int MOLD_DATA_W     = 64;
    localparam int MOLD_KEEP_LW    = 4;
    localparam int MOLD_OV_DATA_W  = 48;
    localparam int MOLD_OV_KEEP_LW = 3;

    typedef struct packed {
        logic                    start;
        logic [MOLD_KEEP_LW-1:0] len;
        logic [MOLD_DATA_W-1:0]  data;
    } mold_buf_entry_t;
endpackage

// File: rtl/mold_buf_ram.sv
// Entry storage for mold_msg_buf: two write ports, one asynchronous read port.
module mold_buf_ram
    import mold_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_a,
    input  logic [AW-1:0]   addr_a,
    input  mold_buf_entry_t din_a,
    input  logic            we_b,
    input  logic [AW-1:0]   addr_b,
    input  mold_buf_entry_t din_b,
    input  logic [AW-1:0]   raddr,
    output mold_buf_entry_t dout
);
    mold_buf_entry_t mem [DEPTH];

    // The top never issues both ports to the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    assign dout = mem[raddr];
endmodule

// File: rtl/mold_msg_buf.sv
// Segment FIFO between the MoldUDP64 depacketiser and the ITCH decoder; drops whole messages when full.
// Optional MOLD_BUF_STATS_EN adds saturating accepted/dropped start-segment counters.
module mold_msg_buf
    import mold_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = MOLD_DATA_W,
    parameter int KEEP_LW    = MOLD_KEEP_LW,
    parameter int OV_DATA_W  = MOLD_OV_DATA_W,
    parameter int OV_KEEP_LW = MOLD_OV_KEEP_LW
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  msg_v_i,
    input  logic                  msg_start_i,
    input  logic [KEEP_LW-1:0]    msg_len_i,
    input  logic [DATA_W-1:0]     msg_data_i,
    input  logic                  ov_v_i,
    input  logic                  ov_start_i,
    input  logic [OV_KEEP_LW-1:0] ov_len_i,
    input  logic [OV_DATA_W-1:0]  ov_data_i,
    output logic                  out_v_o,
    input  logic                  out_ready_i,
    output logic                  out_start_o,
    output logic [KEEP_LW-1:0]    out_len_o,
    output logic [DATA_W-1:0]     out_data_o,
`ifdef MOLD_BUF_STATS_EN
    output logic [31:0]           stat_msg_cnt_o,
    output logic [31:0]           stat_drop_cnt_o,
`endif
    output logic                  overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr, count, free, free1;
    logic        drop_q, drop_mid, drop_nxt;
    logic        m_disc, m_eval, m_acc, m_rej;
    logic        o_disc, o_eval, o_acc, o_rej;
    logic        pop;
    mold_buf_entry_t ent_m, ent_o, ent_rd;

    // Space comes only from registered pointers; a same-cycle pop gives no credit.
    assign count = wr_ptr - rd_ptr;
    assign free  = DEPTH_P - count;

    always_comb begin
        m_disc   = msg_v_i & drop_q & ~msg_start_i;
        m_eval   = msg_v_i & ~m_disc;
        m_acc    = m_eval & (free != '0);
        m_rej    = m_eval & (free == '0);
        drop_mid = m_eval ? m_rej : drop_q;
        free1    = free - {{AW{1'b0}}, m_acc};
        o_disc   = ov_v_i & drop_mid & ~ov_start_i;
        o_eval   = ov_v_i & ~o_disc;
        o_acc    = o_eval & (free1 != '0);
        o_rej    = o_eval & (free1 == '0);
        drop_nxt = o_eval ? o_rej : drop_mid;
    end

    assign ent_m = '{start: msg_start_i, len: msg_len_i, data: msg_data_i};
    assign ent_o = '{start: ov_start_i, len: KEEP_LW'(ov_len_i), data: DATA_W'(ov_data_i)};

    mold_buf_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .we_a   (m_acc),
        .addr_a (wr_ptr[AW-1:0]),
        .din_a  (ent_m),
        .we_b   (o_acc),
        .addr_b (wr_ptr[AW-1:0] + {{(AW-1){1'b0}}, m_acc}),
        .din_b  (ent_o),
        .raddr  (rd_ptr[AW-1:0]),
        .dout   (ent_rd)
    );

    assign out_v_o     = (wr_ptr != rd_ptr);
    assign out_start_o = ent_rd.start;
    assign out_len_o   = ent_rd.len;
    assign out_data_o  = ent_rd.data;
    assign pop         = out_v_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_q     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + {{AW{1'b0}}, m_acc} + {{AW{1'b0}}, o_acc};
            rd_ptr     <= rd_ptr + {{AW{1'b0}}, pop};
            drop_q     <= drop_nxt;
            overflow_o <= m_rej | m_disc | o_rej | o_disc;
        end
    end

`ifdef MOLD_BUF_STATS_EN
    logic [1:0]  msg_inc, drop_inc;
    logic [32:0] msg_sum, drop_sum;

    assign msg_inc  = {1'b0, m_acc & msg_start_i} + {1'b0, o_acc & ov_start_i};
    assign drop_inc = {1'b0, m_rej & msg_start_i} + {1'b0, o_rej & ov_start_i};
    assign msg_sum  = {1'b0, stat_msg_cnt_o}  + 33'(msg_inc);
    assign drop_sum = {1'b0, stat_drop_cnt_o} + 33'(drop_inc);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            stat_msg_cnt_o  <= '0;
            stat_drop_cnt_o <= '0;
        end else begin
            stat_msg_cnt_o  <= msg_sum[32]  ? '1 : msg_sum[31:0];
            stat_drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_mold_msg_buf.sv
// Directed + random bench for mold_msg_buf against a queue-based message buffer model.
module tb_mold_msg_buf;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        nreset;
    logic        msg_v_i, msg_start_i;
    logic [3:0]  msg_len_i;
    logic [63:0] msg_data_i;
    logic        ov_v_i, ov_start_i;
    logic [2:0]  ov_len_i;
    logic [47:0] ov_data_i;
    logic        out_v_o, out_ready_i, out_start_o, overflow_o;
    logic [3:0]  out_len_o;
    logic [63:0] out_data_o;
`ifdef MOLD_BUF_STATS_EN
    logic [31:0] stat_msg_cnt_o, stat_drop_cnt_o;
`endif

    mold_msg_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nreset(nreset),
        .msg_v_i(msg_v_i), .msg_start_i(msg_start_i), .msg_len_i(msg_len_i), .msg_data_i(msg_data_i),
        .ov_v_i(ov_v_i), .ov_start_i(ov_start_i), .ov_len_i(ov_len_i), .ov_data_i(ov_data_i),
        .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_start_o(out_start_o),
        .out_len_o(out_len_o), .out_data_o(out_data_o),
`ifdef MOLD_BUF_STATS_EN
        .stat_msg_cnt_o(stat_msg_cnt_o), .stat_drop_cnt_o(stat_drop_cnt_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          start;
        int          len;
        logic [63:0] data;
    } seg_t;

    seg_t q[$];
    bit   m_drop;
    bit   m_ovf;
    int   m_msgs, m_drops;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one segment arriving: discard, accept or reject against the remaining room.
    task automatic offer(input bit st, input int len, input logic [63:0] data,
                         inout int room, inout seg_t push[$]);
        seg_t s;
        if (m_drop && !st) begin
            m_ovf = 1'b1;
            return;
        end
        m_drop = 1'b0;
        if (room > 0) begin
            s.start = st; s.len = len; s.data = data;
            push.push_back(s);
            room--;
            if (st) m_msgs++;
        end else begin
            m_drop = 1'b1;
            m_ovf  = 1'b1;
            if (st) m_drops++;
        end
    endtask

    task automatic cycle(input bit mv, input bit ms, input int ml, input logic [63:0] md,
                         input bit ov, input bit os, input int ol, input logic [47:0] od,
                         input bit rdy);
        seg_t push[$];
        int   room;
        bit   pop;
        msg_v_i = mv; msg_start_i = ms; msg_len_i = 4'(ml); msg_data_i = md;
        ov_v_i = ov; ov_start_i = os; ov_len_i = 3'(ol); ov_data_i = od;
        out_ready_i = rdy;
        pop   = rdy && q.size() > 0;
        room  = DEPTH - q.size();
        m_ovf = 1'b0;
        if (nreset) begin
            if (mv) offer(ms, ml, md, room, push);
            if (ov) offer(os, ol, 64'(od), room, push);
        end
        @(posedge clk);
        #1;
        if (!nreset) begin
            q.delete();
            m_drop = 1'b0; m_ovf = 1'b0; m_msgs = 0; m_drops = 0;
        end else begin
            if (pop) void'(q.pop_front());
            foreach (push[i]) q.push_back(push[i]);
        end
        chk("out_v", 64'(out_v_o), 64'(q.size() > 0));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        if (q.size() > 0) begin
            chk("out_start", 64'(out_start_o), 64'(q[0].start));
            chk("out_len", 64'(out_len_o), 64'(q[0].len));
            chk("out_data", out_data_o, q[0].data);
        end
`ifdef MOLD_BUF_STATS_EN
        chk("stat_msg", 64'(stat_msg_cnt_o), 64'(m_msgs));
        chk("stat_drop", 64'(stat_drop_cnt_o), 64'(m_drops));
`endif
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 1, 64'h0, 0, 0, 1, 48'h0, rdy);
    endtask

    task automatic seg(input bit st, input int len, input bit rdy);
        cycle(1, st, len, {$urandom, $urandom}, 0, 0, 1, 48'h0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) idle(1);
        chk("drained", 64'(out_v_o), 64'(0));
    endtask

    initial begin
        nreset = 1'b0;
        idle(0);
        idle(0);
        nreset = 1'b1;
        idle(0);

        // 1: single segment, one-cycle latency, pop empties
        cycle(1, 1, 8, 64'h0807060504030201, 0, 0, 1, 48'h0, 0);
        idle(1);

        // 2: main cont + overlap start in same beat, overlap zero-extended
        cycle(1, 0, 2, 64'hFFFF_FFFF_FFFF_BEEF, 1, 1, 6, 48'hA1A2A3A4A5A6, 0);
        idle(1);
        drain();

        // 3: fill, overflow, discarded conts, recovery on a start with space
        for (int i = 0; i < DEPTH; i++) seg(1, 1 + (i % 8), 0);
        seg(0, 3, 0);
        seg(0, 4, 0);
        seg(0, 5, 0);
        idle(1);
        seg(1, 8, 0);
        seg(0, 2, 0);
        drain();

        // 4: one slot free, main cont kept, overlap start rejected, its conts discarded
        for (int i = 0; i < DEPTH - 1; i++) seg(1, 7, 0);
        cycle(1, 0, 6, 64'h1122334455667788, 1, 1, 6, 48'hCAFEF00DBEEF, 0);
        seg(0, 5, 1);
        seg(0, 8, 1);
        drain();

        // 5: full + pop + write: write rejected, count goes to 15
        for (int i = 0; i < DEPTH; i++) seg(1, 8, 0);
        seg(1, 4, 1);
        chk("count_after_pop", 64'(q.size()), 64'(DEPTH - 1));
        drain();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), $urandom_range(1, 8),
                  {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0), $urandom_range(1, 6),
                  48'({$urandom, $urandom}),
                  ($urandom_range(0, 9) < 4));
        end
        drain();

        // 6: reset mid-operation flushes queued entries
        for (int i = 0; i < 5; i++) seg(1, 8, 0);
        nreset = 1'b0;
        idle(0);
        nreset = 1'b1;
        idle(1);
        seg(1, 2, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
